alu_operand_sequencer: RTL
==========================

// Module: alu_operand_sequencer
// PURPOSE
//  Control-side master for the ALU operand path: issues the ITEMP/O_1 strobes the TEMP register
//  consumes, plus register-file bus enables and ALU controls, to run one bus transfer/ALU op.
//  Sits between instruction decode (start/opcode/src/dst) and datapath (regfile, TEMP, ALU, cpu_bus).
//  Guarantees at most one cpu_bus driver per cycle; ALU first operand is always accumulator r0.
// PARAMETERS
//  NREG     8   number of registers on cpu_bus (r0 = accumulator)
//  SEL_W    3   width of src/dst select, = clog2(NREG)
// PORTS
//  clk      in   1        single clock, rising edge
//  rst      in   1        synchronous, active-high reset
//  start    in   1        request; sampled only in IDLE
//  opcode   in   3        000 MOV,001 ADD,010 SUB,011 AND,100 OR,101 INC,110 DEC,111 illegal
//  src_sel  in   SEL_W    source register (MOV source, ALU 2nd operand)
//  dst_sel  in   SEL_W    destination register
//  src_oe   out  NREG     one-hot: register drives cpu_bus
//  dst_ie   out  NREG     one-hot: register loads from cpu_bus
//  ITEMP    out  1        TEMP register load enable
//  O_1      out  1        force TEMP output to 8'h01 (+1 operand)
//  alu_oe   out  1        ALU result drives cpu_bus
//  alu_op   out  2        00 ADD,01 SUB,10 AND,11 OR
//  busy     out  1        high from cycle after accepted start until DONE
//  done     out  1        one-cycle pulse, op complete
//  err      out  1        one-cycle pulse with done for illegal opcode
// BEHAVIOUR
//  - Reset: state=IDLE; src_oe,dst_ie=0; ITEMP,O_1,alu_oe,busy,done,err=0; alu_op=00.
//    rst wins over everything, including mid-op: outputs all zero after that edge; no partial write.
//  - All outputs registered (Moore, decoded from next state); no combinational input->output path.
//  - start, opcode, src_sel, dst_sel latched at the accepting edge; changes later are ignored.
//    start while busy/DONE is ignored (no queueing).
//  - States: IDLE, XFER, LOADT, EXEC, DONE.
//    IDLE  --start,MOV-->         XFER ; src_oe[src]=1, dst_ie[dst]=1
//    IDLE  --start,ADD/SUB/AND/OR--> LOADT ; src_oe[src]=1, ITEMP=1
//    IDLE  --start,INC/DEC-->     EXEC ; O_1=1, alu_op=ADD/SUB
//    IDLE  --start,illegal-->     DONE ; err=1
//    LOADT --> EXEC ; alu_oe=1, dst_ie[dst]=1, alu_op per opcode, O_1=0
//    XFER,EXEC --> DONE ; done=1, all enables 0
//    DONE  --> IDLE
//  - Latency, accept edge N: MOV/INC/DEC done in cycle N+2; 2-operand ALU ops in N+3;
//    illegal in N+1. busy high from N+1 until the cycle before done.
//  - O_1 held high for all of EXEC on INC/DEC (TEMP output combinational); ITEMP never
//    asserted with O_1 or alu_oe.
//  - Bus rule: in any cycle popcount(src_oe)+alu_oe <= 1; popcount(dst_ie) <= 1.
//  - src==dst allowed (MOV is a no-op write). dst=r0 on ALU op overwrites accumulator.
//  - Back-to-back: new start accepted in the cycle after DONE (earliest N+3 for MOV).
// STRUCTURE
//  - Shared package/header (cpu_defs): opcode localparams OP_MOV..OP_ILL, ALU_ADD..ALU_OR,
//    state encodings S_IDLE..S_DONE, NREG/SEL_W defaults.
//  - One sub-module natural: onehot_decoder (SEL_W -> NREG with enable), used for src_oe, dst_ie.
//  - Remainder: latched request regs, state reg, next-state/output decode in one always block.
// TESTING
//  - MOV r3->r5 -> src_oe=8'b0000_1000, dst_ie=8'b0010_0000 in N+1; done in N+2; no ITEMP.
//  - ADD src=r2,dst=r0 -> N+1: src_oe=8'h04,ITEMP=1; N+2: alu_oe=1,dst_ie=8'h01,alu_op=00; done N+3.
//  - INC dst=r0 / DEC dst=r4 -> N+1: O_1=1, alu_oe=1, ITEMP=0, alu_op=00/01; done N+2.
//  - start pulsed each cycle during ADD with other opcode -> ignored; exactly one done, ops per first.
//  - rst asserted during LOADT of SUB -> next edge all outputs 0, IDLE; no dst_ie ever asserted.
//  - opcode 111 -> done=1 and err=1 in N+1, no enables; every-cycle assertion of bus-rule counts.

Source files
------------

// File: rtl/alu_operand_sequencer_pkg.sv
// Shared definitions for the ALU operand sequencer:
// opcodes, ALU controls, FSM states and the opcode-to-ALU mapping.
package alu_operand_sequencer_pkg;

    localparam int NREG_DEF  = 8;
    localparam int SEL_W_DEF = 3;

    localparam logic [2:0] OP_MOV = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_INC = 3'b101;
    localparam logic [2:0] OP_DEC = 3'b110;
    localparam logic [2:0] OP_ILL = 3'b111;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_XFER  = 3'd1,
        S_LOADT = 3'd2,
        S_EXEC  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // INC/DEC reuse the adder with the +1 operand from TEMP.
    function automatic logic [1:0] alu_of(input logic [2:0] op);
        logic [1:0] r;
        case (op)
            OP_SUB, OP_DEC: r = ALU_SUB;
            OP_AND:         r = ALU_AND;
            OP_OR:          r = ALU_OR;
            default:        r = ALU_ADD;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_operand_sequencer_onehot_decoder.sv
// Binary select to one-hot register enable, gated by en_i.
// Used for both the bus-drive and bus-load enables.
module alu_operand_sequencer_onehot_decoder #(
    parameter int SEL_W = 3,
    parameter int NREG  = 8
) (
    input  logic             en_i,
    input  logic [SEL_W-1:0] sel_i,
    output logic [NREG-1:0]  oh_o
);

    // At most one bit set, none when disabled.
    always_comb begin
        oh_o = '0;
        for (int i = 0; i < NREG; i++) begin
            oh_o[i] = en_i && (sel_i == SEL_W'(i));
        end
    end

endmodule

// File: rtl/alu_operand_sequencer.sv
// Control master for the ALU operand path: sequences regfile bus
// enables, TEMP strobes and ALU controls for one transfer or ALU op.
module alu_operand_sequencer
    import alu_operand_sequencer_pkg::*;
#(
    parameter int NREG  = NREG_DEF,
    parameter int SEL_W = SEL_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       opcode,
    input  logic [SEL_W-1:0] src_sel,
    input  logic [SEL_W-1:0] dst_sel,
    output logic [NREG-1:0]  src_oe,
    output logic [NREG-1:0]  dst_ie,
    output logic             ITEMP,
    output logic             O_1,
    output logic             alu_oe,
    output logic [1:0]       alu_op,
    output logic             busy,
    output logic             done,
    output logic             err
);

    state_t           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [SEL_W-1:0] src_q, src_d;
    logic [SEL_W-1:0] dst_q, dst_d;
    logic [SEL_W-1:0] sel_src, sel_dst;
    logic             src_en_d, dst_en_d;
    logic [NREG-1:0]  src_oe_d, dst_ie_d;
    logic [NREG-1:0]  src_oe_q, dst_ie_q;
    logic             itemp_d, itemp_q;
    logic             o1_d, o1_q;
    logic             alu_oe_d, alu_oe_q;
    logic [1:0]       alu_op_d, alu_op_q;
    logic             busy_d, busy_q;
    logic             done_d, done_q;
    logic             err_d, err_q;

    // Next state and Moore outputs decoded from the state being entered.
    // On accept the select inputs feed the decoders directly, since
    // the latched copies only become valid after this edge.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        src_d    = src_q;
        dst_d    = dst_q;
        sel_src  = src_q;
        sel_dst  = dst_q;
        src_en_d = 1'b0;
        dst_en_d = 1'b0;
        itemp_d  = 1'b0;
        o1_d     = 1'b0;
        alu_oe_d = 1'b0;
        alu_op_d = ALU_ADD;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        err_d    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = opcode;
                    src_d   = src_sel;
                    dst_d   = dst_sel;
                    sel_src = src_sel;
                    sel_dst = dst_sel;
                    case (opcode)
                        OP_MOV: begin
                            state_d  = S_XFER;
                            src_en_d = 1'b1;
                            dst_en_d = 1'b1;
                            busy_d   = 1'b1;
                        end
                        OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                            state_d  = S_LOADT;
                            src_en_d = 1'b1;
                            itemp_d  = 1'b1;
                            busy_d   = 1'b1;
                        end
                        OP_INC, OP_DEC: begin
                            state_d  = S_EXEC;
                            o1_d     = 1'b1;
                            alu_oe_d = 1'b1;
                            dst_en_d = 1'b1;
                            alu_op_d = alu_of(opcode);
                            busy_d   = 1'b1;
                        end
                        default: begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                            err_d   = 1'b1;
                        end
                    endcase
                end
            end
            S_LOADT: begin
                state_d  = S_EXEC;
                alu_oe_d = 1'b1;
                dst_en_d = 1'b1;
                alu_op_d = alu_of(op_q);
                busy_d   = 1'b1;
            end
            S_XFER, S_EXEC: begin
                state_d = S_DONE;
                done_d  = 1'b1;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    alu_operand_sequencer_onehot_decoder #(
        .SEL_W (SEL_W),
        .NREG  (NREG)
    ) u_src_dec (
        .en_i  (src_en_d),
        .sel_i (sel_src),
        .oh_o  (src_oe_d)
    );

    alu_operand_sequencer_onehot_decoder #(
        .SEL_W (SEL_W),
        .NREG  (NREG)
    ) u_dst_dec (
        .en_i  (dst_en_d),
        .sel_i (sel_dst),
        .oh_o  (dst_ie_d)
    );

    // State, latched request and registered outputs; reset clears all.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= OP_MOV;
            src_q    <= '0;
            dst_q    <= '0;
            src_oe_q <= '0;
            dst_ie_q <= '0;
            itemp_q  <= 1'b0;
            o1_q     <= 1'b0;
            alu_oe_q <= 1'b0;
            alu_op_q <= ALU_ADD;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            src_oe_q <= src_oe_d;
            dst_ie_q <= dst_ie_d;
            itemp_q  <= itemp_d;
            o1_q     <= o1_d;
            alu_oe_q <= alu_oe_d;
            alu_op_q <= alu_op_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign src_oe = src_oe_q;
    assign dst_ie = dst_ie_q;
    assign ITEMP  = itemp_q;
    assign O_1    = o1_q;
    assign alu_oe = alu_oe_q;
    assign alu_op = alu_op_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;

endmodule
